sar_adc: RTL and testbench
==========================

# sar_adc

Successive-approximation ADC controller closing the loop around the 8-bit R2R DAC. It drives the ladder with trial codes and reads back an external analog comparator (Vin vs. Vdac). It binary-searches WIDTH bits and presents the resulting code with a one-cycle valid strobe. It is the read-side counterpart of the waveform generators, sharing the same R2R ladder pins and the board clock.

## Interface
- WIDTH, 8: resolution in bits; sets the widths of R2R_out and data_out.
- SETTLE_CLKS, 100: clocks spent on each trial bit for DAC/comparator settling. Must be ≥ 3 to cover synchronizer latency; elaboration fails otherwise.
- clk  in  1: system clock, 100 MHz.
- reset_n  in  1: asynchronous, active-low reset.
- enable  in  1: block enable. When low, the controller idles and any conversion in progress is aborted.
- start  in  1: conversion request. Sampled only in IDLE.
- comp_in  in  1: asynchronous comparator output. 1 when Vin ≥ Vdac.
- R2R_out  out  WIDTH: trial code to the DAC ladder.
- busy  out  1: high while a conversion is in progress.
- data_out  out  WIDTH: last completed conversion result, held until overwritten.
- data_valid  out  1: one-cycle pulse, coincident with the cycle data_out updates.

## Operation
- comp_in passes through a 2-flop synchronizer to produce comp_s. The controller never uses comp_in directly.
- FSM states:
  - IDLE: R2R_out=0, busy=0.
  - CONV: R2R_out=trial, busy=1.
- IDLE→CONV when enable&&start:
  - trial ← 1<<(WIDTH-1)
  - bit index idx ← WIDTH-1
  - settle counter cnt ← 0
- In CONV, cnt counts 0..SETTLE_CLKS-1. At the edge where cnt==SETTLE_CLKS-1 (decision edge):
  - trial[idx] is kept if comp_s=1, cleared if comp_s=0.
  - If idx>0: set trial[idx-1], idx ← idx-1, cnt ← 0, remain in CONV.
  - If idx==0: data_out ← decided trial, data_valid ← 1, return to IDLE.
- Result is the largest code whose DAC voltage is ≤ Vin (floor quantization).
- start is ignored while busy. If start is held high, a new conversion begins on the first IDLE cycle, so IDLE lasts exactly one cycle between back-to-back conversions.
- enable low in any state: at the next edge go to IDLE with R2R_out=0, busy=0, cnt=0 and no data_valid pulse. data_out keeps its previous value.
- enable low coinciding with a decision edge: the abort wins and no result is written.
- Counter and idx arithmetic is unsigned. cnt width is $clog2(SETTLE_CLKS). idx width is $clog2(WIDTH), minimum 1.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, R2R_out=0, data_out=0, data_valid=0, busy=0, synchronizer flops=0.
- Reset deassertion takes effect at the next clk edge. Reset asserted mid-conversion clears all outputs immediately, without waiting for clk.
- start sampled high at edge E0: busy=1 and R2R_out=MSB-only from E0. The first decision is at E0+SETTLE_CLKS.
- Latency: data_valid is high for exactly one cycle, starting at edge E0+WIDTH·SETTLE_CLKS. This is 800 clocks for the defaults, about 125 kS/s.
- comp_s sampled at a decision edge reflects comp_in from two clocks earlier. The last 2 cycles of each settle window are therefore effectively the sample window.
- data_out is registered and stable between data_valid pulses. busy falls on the same edge data_valid rises.

## Structure
- The shared package holds:
  - sar_state_t enum {IDLE, CONV}
  - SAR_MIN_SETTLE = 3 constant, used in the parameter check
- One sub-module, sync_2ff, a generic single-bit synchronizer reusable by other blocks taking asynchronous board inputs.
- No PWM output. The DAC path is R2R only.

## Test plan
- Bench comparator model: comp_in = (vin_code ≥ R2R_out).
- WIDTH=8, SETTLE_CLKS=4, vin=0xA5, start pulse at E0:
  - R2R_out sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5, each held 4 cycles.
  - data_valid single pulse at E0+32 with data_out=0xA5.
- Boundaries: vin=0x00 → data_out=0x00; vin=0xFF → data_out=0xFF. R2R_out trial for 0xFF ends 0xFF and busy clears on the same edge.
- start pulsed again mid-conversion gives no effect: exactly one data_valid. start held high gives conversions back-to-back with one IDLE cycle between, every 33 cycles.
- enable dropped at cycle E0+10:
  - Next edge: R2R_out=0, busy=0.
  - No data_valid.
  - data_out retains the prior result, e.g. 0xA5.
- reset_n pulsed low between clk edges mid-conversion: all outputs 0 before the next edge. After release, start → correct fresh conversion.
- Elaborating with SETTLE_CLKS=2 fails the parameter assertion.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// -----------------------------------------------------------------------------
// sar_adc_pkg
// Items shared by the SAR ADC controller and its helper:
//   sar_state_t     - controller FSM states (IDLE, CONV)
//   SAR_MIN_SETTLE  - smallest legal settle window; it must cover the two
//                     synchronizer flops plus the decision cycle
//   sar_idx_width() - width of the bit-index register (never below 1)
// -----------------------------------------------------------------------------
package sar_adc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } sar_state_t;

  localparam int unsigned SAR_MIN_SETTLE = 32'd3;

  // Bit-index width for a WIDTH-bit search, clamped to at least one bit
  function automatic int unsigned sar_idx_width(input int unsigned w);
    int unsigned lg;
    lg = $clog2(w);
    if (lg < 32'd1) begin
      return 32'd1;
    end else begin
      return lg;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic single-bit two-flop synchronizer for asynchronous board inputs.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears both flops
//   d_i    - asynchronous input
//   q_o    - synchronized output, two destination clocks behind d_i
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; only sync_q is allowed to fan out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sar_adc.sv
// -----------------------------------------------------------------------------
// sar_adc
// Successive-approximation controller around the R2R DAC ladder. It drives
// trial codes to the ladder, reads an external comparator (Vin >= Vdac) and
// binary-searches WIDTH bits, MSB first, spending SETTLE_CLKS clocks per bit.
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   enable     - block enable; low aborts any conversion and idles
//   start      - conversion request, honoured only in IDLE
//   comp_in    - asynchronous comparator output (1 when Vin >= Vdac)
//   R2R_out    - trial code to the ladder (0 while idle)
//   busy       - high while converting
//   data_out   - last completed result, held until overwritten
//   data_valid - one-cycle pulse when data_out updates
// -----------------------------------------------------------------------------
module sar_adc
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH       = 32'd8,
  parameter int unsigned SETTLE_CLKS = 32'd100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             comp_in,
  output logic [WIDTH-1:0] R2R_out,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);

  localparam int unsigned      CNT_W     = $clog2(SETTLE_CLKS);
  localparam int unsigned      IDX_W     = sar_idx_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CLKS - 32'd1);
  localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 32'd1);
  localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_HOT0  = {{(WIDTH-1){1'b0}}, 1'b1};

  // A shorter window would decide before the comparator reaches comp_s
  if (SETTLE_CLKS < SAR_MIN_SETTLE) begin : g_settle_check
    $error("sar_adc: SETTLE_CLKS must be at least SAR_MIN_SETTLE (3)");
  end

  sar_state_t       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;

  logic             comp_s;
  logic [WIDTH-1:0] bit_mask_s;
  logic [WIDTH-1:0] decided_s;

  sync_2ff u_comp_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (comp_in),
    .q_o    (comp_s)
  );

  // Trial code with the bit under test replaced by the comparator verdict
  always_comb begin
    bit_mask_s = ONE_HOT0 << idx_q;
    if (comp_s) begin
      decided_s = trial_q | bit_mask_s;
    end else begin
      decided_s = trial_q & ~bit_mask_s;
    end
  end

  // Next-state logic; enable low overrides everything, including a decision
  always_comb begin
    state_d = state_q;
    trial_d = trial_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    if (!enable) begin
      state_d = IDLE;
      trial_d = {WIDTH{1'b0}};
      idx_d   = {IDX_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CONV;
            trial_d = TRIAL_MSB;
            idx_d   = IDX_MSB;
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b1;
          end else begin
            trial_d = {WIDTH{1'b0}};
            busy_d  = 1'b0;
          end
        end
        CONV: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (idx_q != {IDX_W{1'b0}}) begin
              // keep the verdict and raise the next lower trial bit
              trial_d = decided_s | (bit_mask_s >> 1);
              idx_d   = idx_q - IDX_W'(1);
            end else begin
              data_d  = decided_s;
              valid_d = 1'b1;
              state_d = IDLE;
              trial_d = {WIDTH{1'b0}};
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          trial_d = {WIDTH{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      trial_q <= {WIDTH{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trial_q <= trial_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign R2R_out    = trial_q;
  assign busy       = busy_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_sar_adc.sv
// -----------------------------------------------------------------------------
// tb_sar_adc
// Scoreboard bench for sar_adc (WIDTH=8, SETTLE_CLKS=4). An ideal comparator
// (vin_code >= R2R_out) closes the loop. Expected results are produced by a
// plain binary-search model and queued at stimulus time; a negedge monitor
// pops and compares whenever data_valid is seen.
// -----------------------------------------------------------------------------
module tb_sar_adc;

  localparam int W = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         start;
  logic         comp_in;
  logic [W-1:0] R2R_out;
  logic         busy;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic [W-1:0] vin_code;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int valid_cnt = 0;
  logic [W-1:0] exp_q[$];
  int           valid_cyc_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign comp_in = (vin_code >= R2R_out);

  sar_adc #(.WIDTH(W), .SETTLE_CLKS(S)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .start      (start),
    .comp_in    (comp_in),
    .R2R_out    (R2R_out),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ideal SAR result: largest code whose value does not exceed vin
  function automatic logic [W-1:0] model_code(input logic [W-1:0] vin);
    logic [W-1:0] code;
    logic [W-1:0] t;
    code = '0;
    for (int b = W - 1; b >= 0; b--) begin
      t = code | (8'd1 << b);
      if (vin >= t) code = t;
    end
    return code;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got data_out 0x%0h expected no pulse (t=%0t)", data_out, $time);
      end else begin
        check("data_out", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full conversion; optionally checks every trial cycle and re-pulses start
  task automatic run_conv(input logic [W-1:0] vin, input int pulse_at, input bit chk_seq);
    logic [W-1:0] seq[W];
    logic [W-1:0] code;
    int e0;
    int vc0;
    vin_code = vin;
    code = '0;
    for (int b = W - 1; b >= 0; b--) begin
      seq[W-1-b] = code | (8'd1 << b);
      if (vin >= seq[W-1-b]) code = seq[W-1-b];
    end
    exp_q.push_back(code);
    vc0 = valid_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e0 = cyc;
    check("busy_at_E0", busy, 1'b1);
    for (int k = 0; k < W; k++) begin
      for (int c = 0; c < S; c++) begin
        start = (pulse_at > 0 && pulse_at == k * S + c) ? 1'b1 : 1'b0;
        if (chk_seq) check($sformatf("r2r_bit%0d_c%0d", k, c), R2R_out, seq[k]);
        tick(1);
      end
    end
    start = 1'b0;
    check("valid_at_E0+32", data_valid, 1'b1);
    check("busy_clear_E0+32", busy, 1'b0);
    check("r2r_idle_E0+32", R2R_out, 8'h00);
    tick(1);
    check("valid_one_cycle", data_valid, 1'b0);
    check("valid_count", valid_cnt, vc0 + 1);
    if (valid_cyc_q.size() > 0) check("valid_cycle", valid_cyc_q[valid_cyc_q.size()-1], e0 + W * S);
    else check("valid_cycle_seen", 0, 1);
  endtask

  initial begin
    int e0;
    int vc0;
    int n0;
    logic [W-1:0] v;

    reset_n  = 1'b0;
    enable   = 1'b1;
    start    = 1'b0;
    vin_code = 8'h00;
    #13;
    check("rst_r2r", R2R_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);

    // Worked example and boundaries
    run_conv(8'hA5, 0, 1'b1);
    run_conv(8'h00, 0, 1'b1);
    run_conv(8'hFF, 0, 1'b1);

    // start re-pulsed mid-conversion has no effect
    run_conv(8'h6E, 10, 1'b1);

    // Random codes
    for (int i = 0; i < 6; i++) begin
      run_conv(8'($urandom_range(0, 255)), 0, 1'b1);
    end

    // start held high: back-to-back conversions every W*S+1 cycles
    v = 8'($urandom_range(0, 255));
    vin_code = v;
    for (int i = 0; i < 3; i++) exp_q.push_back(model_code(v));
    vc0 = valid_cnt;
    n0  = valid_cyc_q.size();
    start = 1'b1;
    tick(1);
    e0 = cyc;
    tick(3 * (W * S + 1) - 1);
    start = 1'b0;
    tick(2);
    check("b2b_count", valid_cnt, vc0 + 3);
    for (int i = 0; i < 3; i++) begin
      if (valid_cyc_q.size() > n0 + i) check($sformatf("b2b_cycle%0d", i), valid_cyc_q[n0+i], e0 + W * S + i * (W * S + 1));
      else check($sformatf("b2b_seen%0d", i), 0, 1);
    end

    // Establish a known result, then abort mid-conversion
    run_conv(8'hA5, 0, 1'b0);
    vin_code = 8'h3C;
    vc0 = valid_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    enable = 1'b0;
    tick(1);
    check("abort_r2r", R2R_out, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_data_kept", data_out, 8'hA5);
    tick(40);
    check("abort_no_valid", valid_cnt, vc0);
    enable = 1'b1;
    tick(2);

    // Abort coinciding with the final decision edge
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(W * S - 1);
    enable = 1'b0;
    tick(1);
    check("abort_final_busy", busy, 1'b0);
    check("abort_final_r2r", R2R_out, 8'h00);
    tick(2);
    check("abort_final_no_valid", valid_cnt, vc0);
    check("abort_final_data", data_out, 8'hA5);
    enable = 1'b1;
    tick(2);

    // Asynchronous reset between edges mid-conversion
    vin_code = 8'h5A;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_r2r", R2R_out, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_data", data_out, 8'h00);
    check("arst_valid", data_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    run_conv(8'($urandom_range(0, 255)), 0, 1'b1);

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
